elink_rx_aligner: RTL

- Byte-recovery stage fed by the 2-bit e-link receive word that the SELECT-IO block produces every clk cycle (80 Mb/s serial, 40 MHz clk).
- Hunts for the sync/flag byte at either bit offset and confirms it with repeated flags before declaring lock.
- Once locked, emits aligned bytes with a valid strobe toward the downstream frame decoder.
- Detects loss of alignment and re-hunts autonomously.

---
 rtl/mopshub_elink_pkg.sv | 19 +
 rtl/elink_flag_detect.sv | 16 +
 rtl/elink_rx_aligner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mopshub_elink_pkg.sv
// Shared e-link receive definitions: aligner state encoding, default flag byte
// and the number of 2-bit pairs that make up one byte.
package mopshub_elink_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } elink_state_t;

    localparam logic [7:0]  ELINK_FLAG           = 8'h7E;
    localparam int unsigned ELINK_PAIRS_PER_BYTE = 4;
    localparam logic [1:0]  ELINK_LAST_PHASE     = 2'(ELINK_PAIRS_PER_BYTE - 1);

    function automatic logic is_boundary(input logic [1:0] phase);
        return (phase == ELINK_LAST_PHASE);
    endfunction

endpackage

// File: rtl/elink_flag_detect.sv
// Compares both candidate byte windows of the receive shift register
// against the flag byte.
module elink_flag_detect
    import mopshub_elink_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = ELINK_FLAG
) (
    input  logic [8:0] sreg,
    output logic       match0,
    output logic       match1
);

    assign match0 = (sreg[7:0] == SYNC_BYTE);
    assign match1 = (sreg[8:1] == SYNC_BYTE);

endmodule

// File: rtl/elink_rx_aligner.sv
// E-link byte aligner: hunts the flag at either bit offset, verifies, locks and
// emits aligned bytes. Define ELINK_RX_ERRCNT_EN to add the err_cnt output.
module elink_rx_aligner
    import mopshub_elink_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = ELINK_FLAG,
    parameter int unsigned SYNC_CNT  = 3,
    parameter int unsigned MAX_GAP   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  rx_elink2bit,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        is_flag,
    output logic        locked,
    output logic        lock_lost
`ifdef ELINK_RX_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [3:0] SYNC_CNT_C = 4'(SYNC_CNT);
    localparam logic [7:0] MAX_GAP_C  = 8'(MAX_GAP);

    // Bit 9 of the nominal 10-bit history never feeds a window, so it is not kept.
    logic [8:0]   sreg_r;
    elink_state_t state_r, state_s;
    logic         offset_r, offset_s;
    logic [1:0]   phase_r, phase_s;
    logic [3:0]   sync_cnt_r, sync_cnt_s;
    logic [7:0]   gap_cnt_r, gap_cnt_s;
    logic [7:0]   data_out_r;
    logic         data_valid_r, is_flag_r, locked_r, lock_lost_r;
    logic         match0_s, match1_s, boundary_s, win_flag_s;
    logic [7:0]   win_s;
    logic         emit_s, lost_s;
`ifdef ELINK_RX_ERRCNT_EN
    logic         vfail_s;
    logic [15:0]  err_cnt_r;
`endif

    elink_flag_detect #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_flag_detect (
        .sreg   (sreg_r),
        .match0 (match0_s),
        .match1 (match1_s)
    );

    assign win_s      = offset_r ? sreg_r[8:1] : sreg_r[7:0];
    assign win_flag_s = (win_s == SYNC_BYTE);
    assign boundary_s = is_boundary(phase_r);

    // Next-state, counter and output-event decode of the alignment FSM.
    always_comb begin
        state_s    = state_r;
        offset_s   = offset_r;
        phase_s    = phase_r + 2'd1;
        sync_cnt_s = sync_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        emit_s     = 1'b0;
        lost_s     = 1'b0;
`ifdef ELINK_RX_ERRCNT_EN
        vfail_s    = 1'b0;
`endif
        if (!en) begin
            state_s    = ST_HUNT;
            phase_s    = 2'd0;
            sync_cnt_s = 4'd0;
            gap_cnt_s  = 8'd0;
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (match0_s || match1_s) begin
                        // Offset 0 takes priority when both windows hold the flag.
                        offset_s   = ~match0_s;
                        phase_s    = 2'd0;
                        sync_cnt_s = 4'd1;
                        gap_cnt_s  = 8'd0;
                        state_s    = (SYNC_CNT_C == 4'd1) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        sync_cnt_s = 4'd0;
                    end
                end
                ST_VERIFY: begin
                    if (!boundary_s) begin
                        state_s = ST_VERIFY;
                    end else if (win_flag_s) begin
                        sync_cnt_s = sync_cnt_r + 4'd1;
                        state_s    = (sync_cnt_s == SYNC_CNT_C) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        state_s    = ST_HUNT;
                        sync_cnt_s = 4'd0;
`ifdef ELINK_RX_ERRCNT_EN
                        vfail_s    = 1'b1;
`endif
                    end
                end
                ST_LOCKED: begin
                    if (!boundary_s) begin
                        state_s = ST_LOCKED;
                    end else begin
                        emit_s = 1'b1;
                        if (win_flag_s) begin
                            gap_cnt_s = 8'd0;
                        end else if ((gap_cnt_r + 8'd1) == MAX_GAP_C) begin
                            state_s    = ST_HUNT;
                            lost_s     = 1'b1;
                            gap_cnt_s  = 8'd0;
                            sync_cnt_s = 4'd0;
                        end else begin
                            gap_cnt_s = gap_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                end
            endcase
        end
    end

    // Shift register and FSM state/counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_r     <= 9'd0;
            state_r    <= ST_HUNT;
            offset_r   <= 1'b0;
            phase_r    <= 2'd0;
            sync_cnt_r <= 4'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            sreg_r     <= {sreg_r[6:0], rx_elink2bit[0], rx_elink2bit[1]};
            state_r    <= state_s;
            offset_r   <= offset_s;
            phase_r    <= phase_s;
            sync_cnt_r <= sync_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
        end
    end

    // Registered outputs; data_out holds the last emitted byte between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_r   <= 8'd0;
            data_valid_r <= 1'b0;
            is_flag_r    <= 1'b0;
            locked_r     <= 1'b0;
            lock_lost_r  <= 1'b0;
        end else begin
            data_out_r   <= emit_s ? win_s : data_out_r;
            data_valid_r <= emit_s;
            is_flag_r    <= emit_s & win_flag_s;
            locked_r     <= (state_s == ST_LOCKED);
            lock_lost_r  <= lost_s;
        end
    end

`ifdef ELINK_RX_ERRCNT_EN
    // Saturating count of alignment failures; only rst clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_r <= 16'd0;
        end else if ((lost_s || vfail_s) && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign is_flag    = is_flag_r;
    assign locked     = locked_r;
    assign lock_lost  = lock_lost_r;

endmodule
